// File: rtl/mw_writeback.sv
// MEM/WB pipeline register and GRF writeback: load extension, result mux, forwarding, retire count.
// Optional GRF_TRACE_EN prints one line per GRF write.
module mw_writeback #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_regwrite,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  m_wdsel,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_dm,
    input  logic [2:0]  m_ldtype,
    input  logic        w_hold,
    input  logic        w_flush,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [4:0]  w_fwd_a3,
    output logic [31:0] w_fwd_wd,
    output logic [31:0] w_pc,
    output logic [31:0] retired
);

    logic        w_valid;
    logic        w_regwrite;
    logic [4:0]  w_a3;
    logic [1:0]  w_wdsel;
    logic [31:0] w_alu;
    logic [31:0] w_dm;
    logic [2:0]  w_ldtype;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            w_valid    <= 1'b0;
            w_pc       <= RESET_PC;
            w_regwrite <= 1'b0;
            w_a3       <= 5'd0;
            w_wdsel    <= 2'd0;
            w_alu      <= 32'd0;
            w_dm       <= 32'd0;
            w_ldtype   <= 3'd0;
        end else if (w_flush) begin
            w_valid    <= 1'b0;
            w_regwrite <= 1'b0;
        end else if (!w_hold) begin
            w_valid    <= m_valid;
            w_pc       <= m_pc;
            w_regwrite <= m_regwrite;
            w_a3       <= m_a3;
            w_wdsel    <= m_wdsel;
            w_alu      <= m_alu;
            w_dm       <= m_dm;
            w_ldtype   <= m_ldtype;
        end
    end

    // An instruction retires when it leaves W without being discarded.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            retired <= 32'd0;
        end else if (w_valid && !w_hold && !w_flush) begin
            retired <= retired + 32'd1;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] result;
    logic        wr;

    always_comb begin
        ld_byte = w_dm[7:0];
        unique case (w_alu[1:0])
            2'd0: ld_byte = w_dm[7:0];
            2'd1: ld_byte = w_dm[15:8];
            2'd2: ld_byte = w_dm[23:16];
            2'd3: ld_byte = w_dm[31:24];
        endcase
    end

    assign ld_half = w_alu[1] ? w_dm[31:16] : w_dm[15:0];

    always_comb begin
        ld_val = w_dm;
        case (w_ldtype)
            3'd1:    ld_val = {24'd0, ld_byte};
            3'd2:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'd3:    ld_val = {16'd0, ld_half};
            3'd4:    ld_val = {{16{ld_half[15]}}, ld_half};
            default: ld_val = w_dm;
        endcase
    end

    always_comb begin
        result = w_alu;
        case (w_wdsel)
            2'd1:    result = ld_val;
            2'd2:    result = w_pc + 32'd8;
            default: result = w_alu;
        endcase
    end

    assign wr       = w_valid & w_regwrite & (w_a3 != 5'd0);
    assign grf_we   = wr;
    assign grf_a3   = wr ? w_a3 : 5'd0;
    assign grf_wd   = wr ? result : 32'd0;
    assign w_fwd_a3 = grf_a3;
    assign w_fwd_wd = grf_wd;

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (!clr && grf_we) begin
            $display("@%h: $%d <= %h", w_pc, grf_a3, grf_wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_mw_writeback.sv
// Directed table-driven bench for mw_writeback plus hold/flush/reset sequences.
module tb_mw_writeback;

    logic        clk = 1'b0;
    logic        clr;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_regwrite;
    logic [4:0]  m_a3;
    logic [1:0]  m_wdsel;
    logic [31:0] m_alu;
    logic [31:0] m_dm;
    logic [2:0]  m_ldtype;
    logic        w_hold;
    logic        w_flush;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [4:0]  w_fwd_a3;
    logic [31:0] w_fwd_wd;
    logic [31:0] w_pc;
    logic [31:0] retired;

    mw_writeback dut (
        .clk(clk), .clr(clr),
        .m_valid(m_valid), .m_pc(m_pc), .m_regwrite(m_regwrite),
        .m_a3(m_a3), .m_wdsel(m_wdsel), .m_alu(m_alu), .m_dm(m_dm),
        .m_ldtype(m_ldtype), .w_hold(w_hold), .w_flush(w_flush),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
        .w_fwd_a3(w_fwd_a3), .w_fwd_wd(w_fwd_wd),
        .w_pc(w_pc), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  a3;
        logic [1:0]  wdsel;
        logic [2:0]  ld;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] dm;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vt[16];
    logic [31:0] exp_ret;
    logic        mv;

    task automatic drive(input vec_t v);
        m_valid    = v.valid;
        m_regwrite = v.rw;
        m_a3       = v.a3;
        m_wdsel    = v.wdsel;
        m_ldtype   = v.ld;
        m_pc       = v.pc;
        m_alu      = v.alu;
        m_dm       = v.dm;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, "_we"}, {31'd0, grf_we}, {31'd0, v.e_we});
        check({tag, "_a3"}, {27'd0, grf_a3}, {27'd0, v.e_a3});
        check({tag, "_wd"}, grf_wd, v.e_wd);
        check({tag, "_fa3"}, {27'd0, w_fwd_a3}, {27'd0, v.e_a3});
        check({tag, "_fwd"}, w_fwd_wd, v.e_wd);
        check({tag, "_pc"}, w_pc, v.pc);
        check({tag, "_ret"}, retired, exp_ret);
    endtask

    localparam logic [31:0] DM = 32'h8765_43A1;

    initial begin
        vt[0]  = '{1, 1, 3, 0, 0, 32'h3000, 32'h1, DM, 1, 3, 32'h1};
        vt[1]  = '{1, 1, 0, 0, 0, 32'h3004, 32'h1, DM, 0, 0, 32'h0};
        vt[2]  = '{1, 1, 4, 1, 2, 32'h3008, 32'h0, DM, 1, 4, 32'hFFFF_FFA1};
        vt[3]  = '{1, 1, 4, 1, 1, 32'h300C, 32'h0, DM, 1, 4, 32'h0000_00A1};
        vt[4]  = '{1, 1, 5, 1, 4, 32'h3010, 32'h2, DM, 1, 5, 32'hFFFF_8765};
        vt[5]  = '{1, 1, 5, 1, 3, 32'h3014, 32'h2, DM, 1, 5, 32'h0000_8765};
        vt[6]  = '{1, 1, 6, 1, 0, 32'h3018, 32'h0, DM, 1, 6, DM};
        vt[7]  = '{1, 1, 6, 1, 6, 32'h301C, 32'h3, DM, 1, 6, DM};
        vt[8]  = '{1, 1, 8, 1, 2, 32'h3020, 32'h3, DM, 1, 8, 32'hFFFF_FF87};
        vt[9]  = '{1, 1, 8, 1, 1, 32'h3024, 32'h1, DM, 1, 8, 32'h0000_0043};
        vt[10] = '{1, 1, 9, 1, 4, 32'h3028, 32'h1, DM, 1, 9, 32'h0000_43A1};
        vt[11] = '{1, 1, 31, 2, 0, 32'h3008, 32'h0, DM, 1, 31, 32'h3010};
        vt[12] = '{1, 1, 31, 2, 0, 32'hFFFF_FFFC, 32'h0, DM, 1, 31, 32'h4};
        vt[13] = '{1, 1, 2, 3, 0, 32'h3030, 32'hDEAD_BEEF, DM, 1, 2, 32'hDEAD_BEEF};
        vt[14] = '{0, 1, 9, 0, 0, 32'h3034, 32'h5, DM, 0, 0, 32'h0};
        vt[15] = '{1, 0, 9, 0, 0, 32'h3038, 32'h5, DM, 0, 0, 32'h0};

        clr = 1'b1;
        w_hold = 1'b0;
        w_flush = 1'b0;
        drive('{0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0});
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", {31'd0, grf_we}, 32'd0);
        check("rst_a3", {27'd0, grf_a3}, 32'd0);
        check("rst_wd", grf_wd, 32'd0);
        check("rst_fa3", {27'd0, w_fwd_a3}, 32'd0);
        check("rst_pc", w_pc, 32'h0000_3000);
        check("rst_ret", retired, 32'd0);
        clr = 1'b0;

        exp_ret = 0;
        mv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(vt[i]);
            @(posedge clk);
            #1;
            if (mv) exp_ret++;
            mv = vt[i].valid;
            check_out($sformatf("v%0d", i), vt[i]);
        end

        // hold three edges while a new instruction waits upstream
        drive(vt[0]);
        @(posedge clk);
        #1;
        if (mv) exp_ret++;
        mv = 1'b1;
        check_out("hload", vt[0]);
        w_hold = 1'b1;
        m_a3 = 5'd7;
        m_pc = 32'h4000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("hold%0d", k), vt[0]);
        end
        w_hold = 1'b0;
        @(posedge clk);
        #1;
        exp_ret++;
        check("rel_a3", {27'd0, grf_a3}, 32'd7);
        check("rel_ret", retired, exp_ret);

        // flush beats hold; the W instruction is dropped uncounted
        w_hold = 1'b1;
        w_flush = 1'b1;
        @(posedge clk);
        #1;
        check("fl_we", {31'd0, grf_we}, 32'd0);
        check("fl_a3", {27'd0, grf_a3}, 32'd0);
        check("fl_ret", retired, exp_ret);
        w_hold = 1'b0;
        w_flush = 1'b0;
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fl2_ret", retired, exp_ret);

        // asynchronous clear between edges with a live write to $5
        m_valid = 1'b1;
        m_a3 = 5'd5;
        m_wdsel = 2'd0;
        m_alu = 32'h55;
        @(posedge clk);
        #1;
        check("ar_pre_we", {31'd0, grf_we}, 32'd1);
        #1;
        clr = 1'b1;
        #1;
        check("ar_we", {31'd0, grf_we}, 32'd0);
        check("ar_pc", w_pc, 32'h0000_3000);
        check("ar_ret", retired, 32'd0);
        #1;
        clr = 1'b0;
        m_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
